// File: rtl/vga_ball_ctrl.sv
// Ball renderer: draws a filled circle over a solid background and moves it once per
// frame, either from debounced push-buttons or by bouncing off the active-area edges.
module vga_ball_ctrl #(
  parameter int          H_VALID      = 640,
  parameter int          V_VALID      = 480,
  parameter int          BALL_RADIUS  = 20,
  parameter int          STEP         = 10,
  parameter int          DEBOUNCE_CYC = 250000,
  parameter int          INIT_X       = 320,
  parameter int          INIT_Y       = 240,
  parameter logic [15:0] BALL_COLOR   = 16'h001F,
  parameter logic [15:0] BG_COLOR     = 16'hF81F
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [3:0]  btn_n,
  input  logic        auto_mode,
  output logic [15:0] pix_data,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        frame_tick
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [9:0]      STEP_V  = 10'(STEP);
  localparam logic [9:0]      X_MIN   = 10'(BALL_RADIUS);
  localparam logic [9:0]      X_MAX   = 10'(H_VALID - 1 - BALL_RADIUS);
  localparam logic [9:0]      Y_MIN   = 10'(BALL_RADIUS);
  localparam logic [9:0]      Y_MAX   = 10'(V_VALID - 1 - BALL_RADIUS);
  localparam logic [22:0]     R_SQ    = 23'(BALL_RADIUS * BALL_RADIUS);

  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  logic [3:0]       sync_q1, sync_q2, stable, press_evt, pending;
  logic [CNT_W-1:0] db_cnt [4];
  logic             cond, cond_d;
  dir_t             dir_x, dir_y;
  logic [10:0]      x_next, y_next;
  logic [10:0]      dx, dy;
  logic [21:0]      dx_sq, dy_sq;
  logic [22:0]      dist_sq;
  logic             active;

  // One axis of the per-frame move; returns {new direction, new position}.
  function automatic logic [10:0] move_axis(input logic [9:0] pos, input logic dec,
                                            input logic inc, input logic auto_en,
                                            input dir_t dir, input logic [9:0] lo,
                                            input logic [9:0] hi);
    dir_t       d;
    logic [9:0] p;
    d = dir;
    p = pos;
    if (auto_en) begin
      if (dec && !inc)      d = DIR_NEG;
      else if (inc && !dec) d = DIR_POS;
      if (d == DIR_POS) begin
        if (pos <= hi - STEP_V) p = pos + STEP_V;
        else begin
          p = hi;
          d = DIR_NEG;
        end
      end else begin
        if (pos >= lo + STEP_V) p = pos - STEP_V;
        else begin
          p = lo;
          d = DIR_POS;
        end
      end
    end else if (dec && !inc) begin
      p = (pos >= lo + STEP_V) ? pos - STEP_V : lo;
    end else if (inc && !dec) begin
      p = (pos <= hi - STEP_V) ? pos + STEP_V : hi;
    end
    return {d, p};
  endfunction

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 4'hF;
      sync_q2 <= 4'hF;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          stable[i] <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_evt = '0;
    for (int i = 0; i < 4; i++)
      press_evt[i] = stable[i] & ~sync_q2[i] & (db_cnt[i] == CNT_MAX);
  end

  // cond_d resets high so a reset released on the last active pixel cannot fake a tick.
  assign cond       = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign frame_tick = cond & ~cond_d;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cond_d  <= 1'b1;
      pending <= '0;
    end else begin
      cond_d  <= cond;
      pending <= (frame_tick ? 4'b0000 : pending) | press_evt;
    end
  end

  assign x_next = move_axis(ball_x, pending[0], pending[1], auto_mode, dir_x, X_MIN, X_MAX);
  assign y_next = move_axis(ball_y, pending[2], pending[3], auto_mode, dir_y, Y_MIN, Y_MAX);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ball_x <= 10'(INIT_X);
      ball_y <= 10'(INIT_Y);
      dir_x  <= DIR_POS;
      dir_y  <= DIR_POS;
    end else if (frame_tick) begin
      ball_x <= x_next[9:0];
      ball_y <= y_next[9:0];
      dir_x  <= dir_t'(x_next[10]);
      dir_y  <= dir_t'(y_next[10]);
    end
  end

  always_comb begin
    dx      = (pix_x >= ball_x) ? {1'b0, pix_x - ball_x} : {1'b0, ball_x - pix_x};
    dy      = (pix_y >= ball_y) ? {1'b0, pix_y - ball_y} : {1'b0, ball_y - pix_y};
    dx_sq   = {11'd0, dx} * {11'd0, dx};
    dy_sq   = {11'd0, dy} * {11'd0, dy};
    dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    active  = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            pix_data <= 16'h0000;
    else if (!active)          pix_data <= 16'h0000;
    else if (dist_sq <= R_SQ)  pix_data <= BALL_COLOR;
    else                       pix_data <= BG_COLOR;
  end

endmodule

// File: tb/tb_vga_ball_ctrl.sv
// Scoreboard bench for vga_ball_ctrl: stimulus queues expected values, a negedge
// monitor pops and compares them once the corresponding output is due.
module tb_vga_ball_ctrl;

  localparam int DB = 4;

  logic        vga_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x     = '0;
  logic [9:0]  pix_y     = '0;
  logic [3:0]  btn_n     = 4'hF;
  logic        auto_mode = 1'b0;
  logic [15:0] pix_data;
  logic [9:0]  ball_x, ball_y;
  logic        frame_tick;

  vga_ball_ctrl #(.DEBOUNCE_CYC(DB)) dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .btn_n      (btn_n),
    .auto_mode  (auto_mode),
    .pix_data   (pix_data),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .frame_tick (frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int          kind;
    string       name;
    logic [15:0] value;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          tick_seen = 0;
  int          tick_exp  = 0;
  int          exp_x, exp_y;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Outputs are compared on the falling edge, one cycle after the stimulus that caused them.
  always @(negedge vga_clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        0:       mon_act = pix_data;
        1:       mon_act = {6'd0, ball_x};
        default: mon_act = {6'd0, ball_y};
      endcase
      checks++;
      if (mon_act !== mon_e.value || mon_e.due != cyc) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h (cycle %0d due %0d)",
                 mon_e.name, mon_act, mon_e.value, cyc, mon_e.due);
      end
    end
  end

  always @(negedge vga_clk) begin
    #2;
    if (frame_tick === 1'b1) tick_seen++;
  end

  task automatic check_output(input int kind, input string name, input logic [15:0] value);
    sb_q.push_back('{kind: kind, name: name, value: value, due: cyc + 1});
  endtask

  task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y,
                                input logic [15:0] exp_pix, input string name);
    @(negedge vga_clk);
    pix_x = x;
    pix_y = y;
    check_output(0, name, exp_pix);
  endtask

  task automatic check_ball(input int x, input int y, input string name);
    check_output(1, {name, "_x"}, 16'(x));
    check_output(2, {name, "_y"}, 16'(y));
  endtask

  task automatic press(input logic [3:0] mask, input int low_cycles);
    @(negedge vga_clk);
    btn_n = ~mask;
    repeat (low_cycles) @(negedge vga_clk);
    btn_n = 4'hF;
    repeat (DB + 6) @(negedge vga_clk);
  endtask

  task automatic do_tick(input int hold);
    @(negedge vga_clk);
    pix_x = 10'd639;
    pix_y = 10'd479;
    repeat (hold) @(negedge vga_clk);
    pix_x = 10'd0;
    pix_y = 10'd0;
    tick_exp++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus(10'd320, 10'd240, 16'h0000, "rst_pix_centre");
    apply_stimulus(10'd0,   10'd0,   16'h0000, "rst_pix_origin");
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    check_ball(320, 240, "after_reset");

    apply_stimulus(10'd320, 10'd240, 16'h001F, "pix_centre");
    apply_stimulus(10'd0,   10'd0,   16'hF81F, "pix_origin");
    apply_stimulus(10'd340, 10'd240, 16'h001F, "pix_edge_in");
    apply_stimulus(10'd341, 10'd240, 16'hF81F, "pix_edge_out");
    apply_stimulus(10'd320, 10'd260, 16'h001F, "pix_edge_in_y");
    apply_stimulus(10'd332, 10'd256, 16'h001F, "pix_diag_in");
    apply_stimulus(10'd333, 10'd256, 16'hF81F, "pix_diag_out");
    apply_stimulus(10'd640, 10'd100, 16'h0000, "pix_blank_x");
    apply_stimulus(10'd100, 10'd480, 16'h0000, "pix_blank_y");
    apply_stimulus(10'd0,   10'd240, 16'hF81F, "pix_no_wrap");
    apply_stimulus(10'd0,   10'd0,   16'hF81F, "pix_back_origin");

    press(4'b0001, 3);
    do_tick(1);
    check_ball(320, 240, "glitch_ignored");

    press(4'b0001, 10);
    do_tick(1);
    check_ball(310, 240, "first_left");

    exp_x = 310;
    for (int i = 0; i < 40; i++) begin
      press(4'b0001, 6);
      do_tick(1);
      exp_x = (exp_x >= 30) ? exp_x - 10 : 20;
      check_ball(exp_x, 240, "left_walk");
    end

    press(4'b0011, 6);
    do_tick(1);
    check_ball(20, 240, "left_right_cancel");

    for (int i = 0; i < 60; i++) begin
      press(4'b0010, 6);
      do_tick(1);
      exp_x = (exp_x + 10 <= 619) ? exp_x + 10 : 619;
      check_ball(exp_x, 240, "right_walk");
    end

    @(negedge vga_clk);
    auto_mode = 1'b1;
    do_tick(1);
    check_ball(619, 250, "auto_clamp");
    do_tick(1);
    check_ball(609, 260, "auto_bounce");
    do_tick(1);
    check_ball(599, 270, "auto_cont");

    press(4'b0100, 6);
    do_tick(1);
    check_ball(589, 260, "auto_up_override");

    @(negedge vga_clk);
    auto_mode = 1'b0;
    do_tick(1);
    check_ball(589, 260, "manual_idle");

    // Left press whose debounce completes exactly in the tick cycle.
    @(negedge vga_clk);
    btn_n = 4'b1110;
    repeat (5) @(negedge vga_clk);
    pix_x = 10'd639;
    pix_y = 10'd479;
    @(negedge vga_clk);
    pix_x = 10'd0;
    pix_y = 10'd0;
    tick_exp++;
    check_ball(589, 260, "press_at_tick");
    repeat (4) @(negedge vga_clk);
    btn_n = 4'hF;
    repeat (DB + 6) @(negedge vga_clk);

    do_tick(3);
    check_ball(579, 260, "press_deferred");

    @(negedge vga_clk);
    auto_mode = 1'b1;
    do_tick(1);
    check_ball(569, 250, "dir_persist");

    repeat (3) @(negedge vga_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    checks++;
    if (tick_seen != tick_exp) begin
      errors++;
      $display("[TB] FAIL frame_tick_count: got %0d expected %0d", tick_seen, tick_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
